// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling with a two-flop input synchronizer.
// Optional stop-bit checking and the rx_frame_err port are enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx #(
    parameter int unsigned clocks_per_bit = 4
) (
    input  logic       ser_clk,
    input  logic       rst_n,
    input  logic       SER_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
`ifdef UART_RX_FRAME_ERR_EN
    output logic       rx_frame_err,
`endif
    output logic       rx_idle
);

    localparam int unsigned TIMER_W = $clog2(clocks_per_bit);
    localparam int unsigned CNT_W   = 4;
    localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(clocks_per_bit / 2);
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(clocks_per_bit - 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         shift;
    logic               sync_q1;
    logic               rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= SER_RX;
            rx_s    <= sync_q1;
        end
    end

    // Frame FSM; rx_idle is updated together with every transition into or out of IDLE.
    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            rx_frame_err <= 1'b0;
`endif
            rx_idle      <= 1'b1;
        end else begin
            rx_valid     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            rx_frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        timer   <= TIMER_W'(1);
                        rx_idle <= 1'b0;
                    end
                end
                START: begin
                    if (timer == HALF_BIT) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_idle <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
`ifdef UART_RX_FRAME_ERR_EN
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            rx_idle  <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
`else
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        state    <= IDLE;
                        rx_idle  <= 1'b1;
`endif
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_idle <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are scheduled as expected output events by cycle number.
// Define UART_RX_FRAME_ERR_EN for both files to exercise stop-bit checking.
module tb_uart_rx;

    localparam int CPB       = 4;
    // Cycles from driving the start edge to the rx_valid pulse: 2 sync flops + stop sample + 1.
    localparam int VALID_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       ser_clk;
    logic       rst_n;
    logic       SER_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_idle;
`ifdef UART_RX_FRAME_ERR_EN
    logic       rx_frame_err;
`endif

    int vectors;
    int miscompares;
    int cyc;

    // Expected events keyed by cycle: bit 8 = frame error, bits 7:0 = byte.
    logic [8:0] exp_ev [int];
    logic [7:0] model_data;

    uart_rx #(.clocks_per_bit(CPB)) dut (
        .ser_clk      (ser_clk),
        .rst_n        (rst_n),
        .SER_RX       (SER_RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
`ifdef UART_RX_FRAME_ERR_EN
        .rx_frame_err (rx_frame_err),
`endif
        .rx_idle      (rx_idle)
    );

    initial begin
        ser_clk = 1'b0;
        forever #5 ser_clk = ~ser_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge ser_clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge ser_clk);
        #1;
    endtask

    // Per-cycle comparison of outputs against the scheduled events.
    initial begin
        logic ev_v;
        logic ev_e;
        model_data = 8'h00;
        forever begin
            @(negedge ser_clk);
            if (!rst_n) begin
                model_data = 8'h00;
                check("rst_data", 32'(rx_data), 32'h0);
                check("rst_valid", 32'(rx_valid), 32'h0);
                check("rst_idle", 32'(rx_idle), 32'h1);
`ifdef UART_RX_FRAME_ERR_EN
                check("rst_ferr", 32'(rx_frame_err), 32'h0);
`endif
            end else begin
                ev_v = 1'b0;
                ev_e = 1'b0;
                if (exp_ev.exists(cyc)) begin
                    if (exp_ev[cyc][8]) begin
                        ev_e = 1'b1;
                    end else begin
                        ev_v = 1'b1;
                        model_data = exp_ev[cyc][7:0];
                    end
                    exp_ev.delete(cyc);
                end
                check("valid", 32'(rx_valid), 32'(ev_v));
`ifdef UART_RX_FRAME_ERR_EN
                check("frame_err", 32'(rx_frame_err), 32'(ev_e));
`endif
                check("data", 32'(rx_data), 32'(model_data));
            end
        end
    end

    // Drive one frame starting now; abort_bit >= 0 pulses reset at the start of that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int abort_bit);
        int         d;
        logic [9:0] bits;
        d    = cyc;
        bits = {stop_lvl, b, 1'b0};
`ifdef UART_RX_FRAME_ERR_EN
        exp_ev[d + VALID_LAT] = stop_lvl ? {1'b0, b} : 9'h100;
`else
        exp_ev[d + VALID_LAT] = {1'b0, b};
`endif
        for (int i = 0; i < 10; i++) begin
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                rst_n  = 1'b0;
                SER_RX = 1'b1;
                exp_ev.delete(d + VALID_LAT);
                repeat (3) tick();
                rst_n = 1'b1;
                return;
            end
            if (i == 5) check("busy_idle", 32'(rx_idle), 32'h0);
            SER_RX = bits[i];
            repeat (CPB) tick();
        end
    endtask

    // Short low pulse that must be rejected at the start-bit sample.
    task automatic glitch(input int len);
        int d;
        d      = cyc;
        SER_RX = 1'b0;
        repeat (len) tick();
        SER_RX = 1'b1;
        while (cyc < d + 3) tick();
        check("glitch_start", 32'(rx_idle), 32'h0);
        while (cyc < d + 2 + CPB / 2 + 1 + 3) tick();
        check("glitch_idle", 32'(rx_idle), 32'h1);
    endtask

    initial begin
        int h;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        SER_RX      = 1'b1;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 32'(rx_idle), 32'h1);

        send_frame(8'hA5, 1'b1, -1);
        repeat (3) tick();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (4) tick();

        glitch(1);
        glitch(CPB / 2);
        repeat (3) tick();

        send_frame(8'h3C, 1'b0, -1);
`ifdef UART_RX_FRAME_ERR_EN
        repeat (3) tick();
        check("wait_high_idle", 32'(rx_idle), 32'h0);
        repeat (3) tick();
        h      = cyc;
        SER_RX = 1'b1;
        tick();
        check("wait_high_hold", 32'(rx_idle), 32'h0);
        while (cyc < h + 4) tick();
        check("wait_high_exit", 32'(rx_idle), 32'h1);
`else
        SER_RX = 1'b1;
`endif
        repeat (6) tick();

        send_frame(8'h55, 1'b1, 4);
        repeat (4) tick();
        check("abort_idle", 32'(rx_idle), 32'h1);
        send_frame(8'h12, 1'b1, -1);
        repeat (4) tick();

        rst_n = 1'b0;
        repeat (2) tick();
        SER_RX = 1'b0;
        tick();
        rst_n = 1'b1;
        send_frame(8'h6B, 1'b1, -1);
        repeat (4) tick();

        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, -1);
        repeat (4) tick();

        for (int n = 0; n < 60; n++) begin
            send_frame(8'($urandom_range(255)), 1'b1, -1);
            repeat ($urandom_range(5)) tick();
            if ($urandom_range(7) == 0) begin
                glitch(int'($urandom_range(CPB / 2, 1)));
                repeat (2) tick();
            end
        end

        repeat (VALID_LAT + 10) tick();
        check("pending", 32'(exp_ev.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
